// File: rtl/key_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_pkg
// Description : Shared types and constants for the push-button debouncer.
//               deb_state_t is the per-channel FSM state; KEY_RELEASED is
//               the synchroniser reset value (active-low key, not pressed).
// Revision    : 1.0 - initial release
// ============================================================================
package key_debounce_pkg;

    typedef enum logic [2:0] {
        ARMING    = 3'd0,
        UP        = 3'd1,
        WAIT_DOWN = 3'd2,
        DOWN      = 3'd3,
        WAIT_UP   = 3'd4
    } deb_state_t;

    localparam logic KEY_RELEASED = 1'b1;

endpackage
`default_nettype wire

// File: rtl/key_debounce_pulse_if.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_pulse_if
// Description : Key bundle between the board buttons and the debouncer.
//               i_key_n   : raw active-low buttons (0 = pressed)
//               o_level   : debounced state (1 = pressed)
//               o_press   : one-cycle pulse on an accepted press
//               o_release : one-cycle pulse on an accepted release
//               master = stimulus / board side, slave = debouncer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_debounce_pulse_if #(
    parameter int N_KEYS = 3
);
    logic [N_KEYS-1:0] i_key_n;
    logic [N_KEYS-1:0] o_level;
    logic [N_KEYS-1:0] o_press;
    logic [N_KEYS-1:0] o_release;

    modport master (
        output i_key_n,
        input  o_level,
        input  o_press,
        input  o_release
    );

    modport slave (
        input  i_key_n,
        output o_level,
        output o_press,
        output o_release
    );
endinterface
`default_nettype wire

// File: rtl/key_debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_channel
// Description : One debounced key: 2-flop synchroniser, stability counter,
//               5-state FSM and registered level / press / release outputs.
//   clk       : system clock
//   rst_n     : synchronous active-low reset
//   i_key_n   : raw asynchronous button, 0 = pressed
//   o_level   : debounced level, 1 = pressed
//   o_press   : one-cycle pulse after an accepted press
//   o_release : one-cycle pulse after an accepted release
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_channel
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int              CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync_q;
    logic             w_pressed;
    deb_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {2{KEY_RELEASED}};
        end else begin
            sync_q <= {sync_q[0], i_key_n};
        end
    end

    assign w_pressed = ~sync_q[1];

    // The transition sample into WAIT_* counts as the first stable sample,
    // which is why the counter is loaded with 1 there rather than 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ARMING;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                // A key held through reset must first be seen released for
                // a full debounce window before any press can be accepted.
                ARMING: begin
                    if (w_pressed) begin
                        cnt_q <= '0;
                    end else if (cnt_q == c_CNT_LAST) begin
                        state_q <= UP;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_ONE;
                    end
                end
                UP: begin
                    if (w_pressed) begin
                        state_q <= WAIT_DOWN;
                        cnt_q   <= c_CNT_ONE;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                WAIT_DOWN: begin
                    if (!w_pressed) begin
                        state_q <= UP;
                        cnt_q   <= '0;
                    end else if (cnt_q == c_CNT_LAST) begin
                        state_q <= DOWN;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_ONE;
                    end
                end
                DOWN: begin
                    if (!w_pressed) begin
                        state_q <= WAIT_UP;
                        cnt_q   <= c_CNT_ONE;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                WAIT_UP: begin
                    if (w_pressed) begin
                        state_q <= DOWN;
                        cnt_q   <= '0;
                    end else if (cnt_q == c_CNT_LAST) begin
                        state_q   <= UP;
                        cnt_q     <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ARMING;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;

endmodule
`default_nettype wire

// File: rtl/key_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_pulse
// Description : N_KEYS independent push-button debouncers producing clean
//               levels and single-cycle press / release pulses.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : key bundle (slave) - i_key_n in; o_level, o_press, o_release out
//   DEBOUNCE_CYCLES must be >= 2.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_pulse
    import key_debounce_pkg::*;
#(
    parameter int N_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    key_debounce_pulse_if.slave   bus
);

    logic [N_KEYS-1:0] w_level;
    logic [N_KEYS-1:0] w_press;
    logic [N_KEYS-1:0] w_release;

    generate
        for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
            key_debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_key_n   (bus.i_key_n[g]),
                .o_level   (w_level[g]),
                .o_press   (w_press[g]),
                .o_release (w_release[g])
            );
        end
    endgenerate

    assign bus.o_level   = w_level;
    assign bus.o_press   = w_press;
    assign bus.o_release = w_release;

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_debounce_pulse
// Description : Directed self-checking bench for key_debounce_pulse with
//               DEBOUNCE_CYCLES = 4, N_KEYS = 3. Accepted edges appear on
//               the 6th clock after the raw key is changed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce_pulse;

    localparam int N_KEYS = 3;
    localparam int DEB    = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    key_debounce_pulse_if #(.N_KEYS(N_KEYS)) kif ();

    key_debounce_pulse #(
        .N_KEYS          (N_KEYS),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        kif.i_key_n = '1;
        tick();
        tick();
        n_checks++;
        if (kif.o_level !== 3'b000) $display("FAIL reset_level got %b want 000", kif.o_level);
        else n_pass++;
        n_checks++;
        if (kif.o_press !== 3'b000) $display("FAIL reset_press got %b want 000", kif.o_press);
        else n_pass++;
        n_checks++;
        if (kif.o_release !== 3'b000) $display("FAIL reset_release got %b want 000", kif.o_release);
        else n_pass++;
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++;
            if ({kif.o_level, kif.o_press, kif.o_release} !== 9'b0)
                $display("FAIL arming_quiet cyc %0d got lvl=%b prs=%b rel=%b want all 0",
                         i, kif.o_level, kif.o_press, kif.o_release);
            else n_pass++;
        end
    endtask

    task automatic test_clean_press();
        kif.i_key_n[0] = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            n_checks++;
            if (kif.o_level[0] !== (i >= 6) || kif.o_press[0] !== (i == 6) || kif.o_release[0] !== 1'b0)
                $display("FAIL clean_press cyc %0d got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=0",
                         i, kif.o_level[0], kif.o_press[0], kif.o_release[0], (i >= 6), (i == 6));
            else n_pass++;
        end
        kif.i_key_n[0] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++;
            if (kif.o_level[0] !== (i < 6) || kif.o_release[0] !== (i == 6) || kif.o_press[0] !== 1'b0)
                $display("FAIL clean_release cyc %0d got lvl=%b prs=%b rel=%b want lvl=%b prs=0 rel=%b",
                         i, kif.o_level[0], kif.o_press[0], kif.o_release[0], (i < 6), (i == 6));
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 13; i++) begin
            kif.i_key_n[1] = (i < 3) ? 1'b0 : 1'b1;
            tick();
            n_checks++;
            if ({kif.o_level[1], kif.o_press[1], kif.o_release[1]} !== 3'b000)
                $display("FAIL glitch cyc %0d got lvl=%b prs=%b rel=%b want all 0",
                         i, kif.o_level[1], kif.o_press[1], kif.o_release[1]);
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        int presses;
        presses = 0;
        // 0,0,1,1,0,0,1,1 then held 0 from c=8 (the final edge).
        for (int c = 0; c < 20; c++) begin
            kif.i_key_n[2] = (c < 8) ? (((c / 2) % 2) == 1) : 1'b0;
            tick();
            if (kif.o_press[2] === 1'b1) presses++;
            n_checks++;
            if (kif.o_press[2] !== (c == 13) || kif.o_release[2] !== 1'b0)
                $display("FAIL bounce cyc %0d got prs=%b rel=%b want prs=%b rel=0",
                         c, kif.o_press[2], kif.o_release[2], (c == 13));
            else n_pass++;
        end
        n_checks++;
        if (presses != 1) $display("FAIL bounce_count got %0d want 1", presses);
        else n_pass++;
        kif.i_key_n[2] = 1'b1;
        repeat (10) tick();
        n_checks++;
        if (kif.o_level[2] !== 1'b0) $display("FAIL bounce_release_level got %b want 0", kif.o_level[2]);
        else n_pass++;
    endtask

    task automatic test_held_reset();
        kif.i_key_n[0] = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_checks++;
            if (kif.o_level[0] !== 1'b0 || kif.o_press[0] !== 1'b0)
                $display("FAIL held_reset cyc %0d got lvl=%b prs=%b want 0 0",
                         i, kif.o_level[0], kif.o_press[0]);
            else n_pass++;
        end
        kif.i_key_n[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++;
            if (kif.o_press[0] !== 1'b0 || kif.o_release[0] !== 1'b0)
                $display("FAIL held_rearm cyc %0d got prs=%b rel=%b want 0 0",
                         i, kif.o_press[0], kif.o_release[0]);
            else n_pass++;
        end
        kif.i_key_n[0] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++;
            if (kif.o_press[0] !== (i == 6) || kif.o_level[0] !== (i >= 6))
                $display("FAIL held_then_press cyc %0d got prs=%b lvl=%b want prs=%b lvl=%b",
                         i, kif.o_press[0], kif.o_level[0], (i == 6), (i >= 6));
            else n_pass++;
        end
        kif.i_key_n[0] = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_simultaneous();
        kif.i_key_n = 3'b100;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++;
            if (kif.o_press !== ((i == 6) ? 3'b011 : 3'b000))
                $display("FAIL simultaneous cyc %0d got prs=%b want %b",
                         i, kif.o_press, (i == 6) ? 3'b011 : 3'b000);
            else n_pass++;
        end
        n_checks++;
        if (kif.o_level !== 3'b011) $display("FAIL simultaneous_level got %b want 011", kif.o_level);
        else n_pass++;
        kif.i_key_n = 3'b111;
        repeat (10) tick();
        n_checks++;
        if (kif.o_level !== 3'b000) $display("FAIL simultaneous_release got %b want 000", kif.o_level);
        else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        kif.i_key_n[0] = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({kif.o_level, kif.o_press, kif.o_release} !== 9'b0)
            $display("FAIL mid_reset got lvl=%b prs=%b rel=%b want all 0",
                     kif.o_level, kif.o_press, kif.o_release);
        else n_pass++;
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++;
            if (kif.o_press[0] !== 1'b0 || kif.o_level[0] !== 1'b0)
                $display("FAIL mid_reset_held cyc %0d got prs=%b lvl=%b want 0 0",
                         i, kif.o_press[0], kif.o_level[0]);
            else n_pass++;
        end
        // Only three released samples: must stay in ARMING.
        kif.i_key_n[0] = 1'b1;
        repeat (3) tick();
        kif.i_key_n[0] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++;
            if (kif.o_press[0] !== 1'b0 || kif.o_level[0] !== 1'b0)
                $display("FAIL short_rearm cyc %0d got prs=%b lvl=%b want 0 0",
                         i, kif.o_press[0], kif.o_level[0]);
            else n_pass++;
        end
        kif.i_key_n[0] = 1'b1;
        repeat (8) tick();
        kif.i_key_n[0] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++;
            if (kif.o_press[0] !== (i == 6) || kif.o_level[0] !== (i >= 6))
                $display("FAIL rearm_press cyc %0d got prs=%b lvl=%b want prs=%b lvl=%b",
                         i, kif.o_press[0], kif.o_level[0], (i == 6), (i >= 6));
            else n_pass++;
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (kif.o_level[0] !== 1'b0) $display("FAIL reset_in_down got lvl=%b want 0", kif.o_level[0]);
        else n_pass++;
        rst_n          = 1'b1;
        kif.i_key_n[0] = 1'b1;
        tick();
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        kif.i_key_n = '1;
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_held_reset();
        test_simultaneous();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
